// File: rtl/ps_bc_route_pkg.sv
// Shared encodings for the program-sequencer bus-connect datapath:
// route select codes, ureg group boundaries and the DM write FSM state type.
package ps_bc_route_pkg;

  localparam logic [1:0] DRR_DAG  = 2'b00;
  localparam logic [1:0] DRR_STK  = 2'b01;
  localparam logic [1:0] DRR_RF   = 2'b10;
  localparam logic [1:0] DRR_NONE = 2'b11;

  localparam logic [2:0] DI_DM       = 3'b000;
  localparam logic [2:0] DI_DM_IADD  = 3'b100;
  localparam logic [2:0] DI_IMM      = 3'b010;
  localparam logic [2:0] DI_DRR      = 3'b001;
  localparam logic [2:0] DI_DRR_IADD = 3'b101;
  localparam logic [2:0] DI_IDLE     = 3'b011;
  localparam int         DI_IADD_BIT = 2;

  // Ureg map: 0-7 register file, 8-11 DAG, 12-15 PC stack.
  localparam logic [3:0] UREG_RF_HI  = 4'h7;
  localparam logic [3:0] UREG_DAG_HI = 4'hB;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_e;

  function automatic logic [1:0] ureg_group(input logic [3:0] ureg);
    if (ureg <= UREG_RF_HI)       return DRR_RF;
    else if (ureg <= UREG_DAG_HI) return DRR_DAG;
    else                          return DRR_STK;
  endfunction

endpackage

// File: rtl/ps_bc_dm_wr_fsm.sv
// DM write handshake: holds the write data and request until the DM accepts it,
// and asks the sequencer to stall while the request is outstanding.
module ps_bc_dm_wr_fsm
  import ps_bc_route_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              launch,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              dm_bc_wr_rdy,
  output logic [DATA_W-1:0] bc_dm_wdata,
  output logic              bc_dm_wr_vld,
  output logic              bc_stall_req
);

  wr_state_e state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WR_IDLE;
      bc_dm_wr_vld <= 1'b0;
      bc_dm_wdata  <= '0;
    end else begin
      case (state)
        WR_IDLE: begin
          if (launch) begin
            state        <= WR_WAIT;
            bc_dm_wr_vld <= 1'b1;
            bc_dm_wdata  <= wdata_in;
          end
        end
        WR_WAIT: begin
          // A write arriving on the completing edge is chained without a bubble.
          if (dm_bc_wr_rdy) begin
            if (launch) begin
              bc_dm_wdata <= wdata_in;
            end else begin
              state        <= WR_IDLE;
              bc_dm_wr_vld <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bc_stall_req = (state == WR_WAIT) & ~dm_bc_wr_rdy;

endmodule

// File: rtl/ps_bc_route.sv
// Bus-connect datapath: decode-stage DRR source mux, execute-stage result route,
// DM write handshake. Define PS_BC_FWD_EN to forward execute results into the DRR.
module ps_bc_route
  import ps_bc_route_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps_stall,
  input  logic [1:0]        ps_bc_drr_slct,
  input  logic [2:0]        ps_bc_di_slct,
  input  logic              ps_bc_dm_wr,
  input  logic [DATA_W-1:0] rf_bc_rdata,
  input  logic [DATA_W-1:0] dag_bc_rdata,
  input  logic [DATA_W-1:0] stk_bc_rdata,
  input  logic [DATA_W-1:0] ps_imm_data,
  input  logic [DATA_W-1:0] dm_bc_rdata,
  input  logic [3:0]        ps_bc_src_ureg,
  input  logic [3:0]        ps_bc_dst_ureg,
  input  logic              ps_bc_dst_we,
  input  logic              dm_bc_wr_rdy,
  output logic [DATA_W-1:0] bc_dst_data,
  output logic              bc_dst_vld,
  output logic              bc_iadd_vld,
  output logic [DATA_W-1:0] bc_dm_wdata,
  output logic              bc_dm_wr_vld,
  output logic              bc_stall_req
);

  logic [DATA_W-1:0] drr_q;
  logic [DATA_W-1:0] drr_src;
  logic [DATA_W-1:0] drr_nxt;
  logic [DATA_W-1:0] exe_res;
  logic              exe_drr_route;
  logic              exe_active;
  logic              exe_wb;
  logic              exe_dm_wr;
  logic              stage_en;

  assign stage_en = ~ps_stall & ~bc_stall_req;

  // Decode stage: pick the internal source for the DRR.
  always_comb begin
    drr_src = '0;
    case (ps_bc_drr_slct)
      DRR_DAG: drr_src = dag_bc_rdata;
      DRR_STK: drr_src = stk_bc_rdata;
      DRR_RF:  drr_src = rf_bc_rdata;
      default: drr_src = '0;
    endcase
  end

  // Execute stage: route DM, immediate or DRR onto the result bus.
  always_comb begin
    exe_res       = '0;
    exe_drr_route = 1'b0;
    exe_active    = 1'b1;
    case (ps_bc_di_slct)
      DI_DM, DI_DM_IADD: exe_res = dm_bc_rdata;
      DI_IMM:            exe_res = ps_imm_data;
      DI_DRR, DI_DRR_IADD: begin
        exe_res       = drr_q;
        exe_drr_route = 1'b1;
      end
      default:           exe_active = 1'b0;
    endcase
  end

  assign exe_dm_wr = exe_drr_route & ps_bc_dm_wr;
  assign exe_wb    = exe_active & ~exe_dm_wr;

`ifdef PS_BC_FWD_EN
  logic fwd_hit;
  // Only forward when the source ureg belongs to the group the decode stage reads.
  assign fwd_hit = ps_bc_dst_we & exe_wb & (ps_bc_drr_slct != DRR_NONE)
                 & (ps_bc_src_ureg == ps_bc_dst_ureg)
                 & (ureg_group(ps_bc_src_ureg) == ps_bc_drr_slct);
  assign drr_nxt = fwd_hit ? exe_res : drr_src;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ps_bc_src_ureg, ps_bc_dst_ureg, ps_bc_dst_we};
  assign drr_nxt    = drr_src;
`endif

  // Stage registers: DRR (decode -> execute) and write-back (execute -> out).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drr_q       <= '0;
      bc_dst_data <= '0;
      bc_dst_vld  <= 1'b0;
      bc_iadd_vld <= 1'b0;
    end else begin
      bc_dst_vld  <= stage_en & exe_wb;
      bc_iadd_vld <= stage_en & exe_wb & ps_bc_di_slct[DI_IADD_BIT];
      if (stage_en) drr_q <= drr_nxt;
      if (stage_en & exe_wb) bc_dst_data <= exe_res;
    end
  end

  ps_bc_dm_wr_fsm #(
    .DATA_W (DATA_W)
  ) u_dm_wr_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .launch       (stage_en & exe_dm_wr),
    .wdata_in     (exe_res),
    .dm_bc_wr_rdy (dm_bc_wr_rdy),
    .bc_dm_wdata  (bc_dm_wdata),
    .bc_dm_wr_vld (bc_dm_wr_vld),
    .bc_stall_req (bc_stall_req)
  );

endmodule

// File: tb/tb_ps_bc_route.sv
// Bench for ps_bc_route: directed vector table, reset/forwarding sequences,
// then random traffic against a cycle model of the routing rules.
module tb_ps_bc_route;

  localparam logic [15:0] DAG_C = 16'hDA60;
  localparam logic [15:0] STK_C = 16'h57C0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps_stall;
  logic [1:0]  ps_bc_drr_slct;
  logic [2:0]  ps_bc_di_slct;
  logic        ps_bc_dm_wr;
  logic [15:0] rf_bc_rdata, dag_bc_rdata, stk_bc_rdata, ps_imm_data, dm_bc_rdata;
  logic [3:0]  ps_bc_src_ureg, ps_bc_dst_ureg;
  logic        ps_bc_dst_we;
  logic        dm_bc_wr_rdy;
  logic [15:0] bc_dst_data, bc_dm_wdata;
  logic        bc_dst_vld, bc_iadd_vld, bc_dm_wr_vld, bc_stall_req;

  ps_bc_route #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ps_stall(ps_stall),
    .ps_bc_drr_slct(ps_bc_drr_slct), .ps_bc_di_slct(ps_bc_di_slct),
    .ps_bc_dm_wr(ps_bc_dm_wr), .rf_bc_rdata(rf_bc_rdata),
    .dag_bc_rdata(dag_bc_rdata), .stk_bc_rdata(stk_bc_rdata),
    .ps_imm_data(ps_imm_data), .dm_bc_rdata(dm_bc_rdata),
    .ps_bc_src_ureg(ps_bc_src_ureg), .ps_bc_dst_ureg(ps_bc_dst_ureg),
    .ps_bc_dst_we(ps_bc_dst_we), .dm_bc_wr_rdy(dm_bc_wr_rdy),
    .bc_dst_data(bc_dst_data), .bc_dst_vld(bc_dst_vld),
    .bc_iadd_vld(bc_iadd_vld), .bc_dm_wdata(bc_dm_wdata),
    .bc_dm_wr_vld(bc_dm_wr_vld), .bc_stall_req(bc_stall_req)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  drr;
    logic [2:0]  di;
    logic        dmwr;
    logic [15:0] rf, imm, dm;
    logic        stall, rdy;
    logic        e_sreq;
    logic [15:0] e_data;
    logic        e_vld, e_iadd;
    logic [15:0] e_wd;
    logic        e_wv;
  } vec_t;

  function automatic vec_t v(input logic [1:0] drr, input logic [2:0] di, input logic dmwr,
                             input logic [15:0] rf, input logic [15:0] imm, input logic [15:0] dm,
                             input logic stall, input logic rdy, input logic e_sreq,
                             input logic [15:0] e_data, input logic e_vld, input logic e_iadd,
                             input logic [15:0] e_wd, input logic e_wv);
    vec_t r;
    r.drr = drr; r.di = di; r.dmwr = dmwr; r.rf = rf; r.imm = imm; r.dm = dm;
    r.stall = stall; r.rdy = rdy; r.e_sreq = e_sreq; r.e_data = e_data;
    r.e_vld = e_vld; r.e_iadd = e_iadd; r.e_wd = e_wd; r.e_wv = e_wv;
    return r;
  endfunction

  vec_t tv[22];

  task automatic idle_inputs();
    ps_stall = 0; ps_bc_drr_slct = 2'b11; ps_bc_di_slct = 3'b011; ps_bc_dm_wr = 0;
    rf_bc_rdata = 0; dag_bc_rdata = DAG_C; stk_bc_rdata = STK_C; ps_imm_data = 0;
    dm_bc_rdata = 0; ps_bc_src_ureg = 0; ps_bc_dst_ureg = 0; ps_bc_dst_we = 0;
    dm_bc_wr_rdy = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk16({tag, "_data"}, bc_dst_data, 16'h0);
    chk1({tag, "_vld"}, bc_dst_vld, 1'b0);
    chk1({tag, "_iadd"}, bc_iadd_vld, 1'b0);
    chk16({tag, "_wdata"}, bc_dm_wdata, 16'h0);
    chk1({tag, "_wvld"}, bc_dm_wr_vld, 1'b0);
    chk1({tag, "_sreq"}, bc_stall_req, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Reference model state: what each output should hold after the next edge.
  logic [15:0] m_drr, m_data, m_wd;
  logic        m_vld, m_iadd, m_wait;

  task automatic model_step(output logic sreq);
    logic        idle, drr_route, wb, dmw, adv, fwd;
    logic [15:0] res, src;
    logic [1:0]  grp;
    sreq = m_wait && !dm_bc_wr_rdy;
    adv  = !ps_stall && !sreq;
    idle = 1; drr_route = 0; res = 16'h0;
    case (ps_bc_di_slct)
      3'd0, 3'd4: begin idle = 0; res = dm_bc_rdata; end
      3'd2:       begin idle = 0; res = ps_imm_data; end
      3'd1, 3'd5: begin idle = 0; res = m_drr; drr_route = 1; end
      default:    idle = 1;
    endcase
    dmw = drr_route && ps_bc_dm_wr;
    wb  = !idle && !dmw;
    case (ps_bc_drr_slct)
      2'd0:    src = dag_bc_rdata;
      2'd1:    src = stk_bc_rdata;
      2'd2:    src = rf_bc_rdata;
      default: src = 16'h0;
    endcase
    grp = (ps_bc_src_ureg <= 4'd7) ? 2'd2 : (ps_bc_src_ureg <= 4'd11) ? 2'd0 : 2'd1;
    fwd = 0;
`ifdef PS_BC_FWD_EN
    fwd = ps_bc_dst_we && wb && ps_bc_drr_slct != 2'd3 &&
          ps_bc_src_ureg == ps_bc_dst_ureg && grp == ps_bc_drr_slct;
`endif
    if (m_wait) begin
      if (dm_bc_wr_rdy) begin
        if (adv && dmw) m_wd = res;
        else m_wait = 0;
      end
    end else if (adv && dmw) begin
      m_wait = 1;
      m_wd   = res;
    end
    m_vld  = adv && wb;
    m_iadd = adv && wb && ps_bc_di_slct >= 3'd4;
    if (adv && wb) m_data = res;
    if (adv) m_drr = fwd ? res : src;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;

    tv[0]  = v(2'b10, 3'b011, 0, 16'h1234, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    tv[1]  = v(2'b11, 3'b001, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 1, 0, 16'h0000, 0);
    tv[2]  = v(2'b00, 3'b010, 0, 0, 16'hBEEF, 0, 0, 0, 0, 16'hBEEF, 1, 0, 16'h0000, 0);
    tv[3]  = v(2'b01, 3'b100, 0, 0, 0, 16'h00A5, 0, 0, 0, 16'h00A5, 1, 1, 16'h0000, 0);
    tv[4]  = v(2'b11, 3'b101, 0, 0, 0, 0, 0, 0, 0, 16'h57C0, 1, 1, 16'h0000, 0);
    tv[5]  = v(2'b11, 3'b011, 0, 0, 0, 0, 0, 0, 0, 16'h57C0, 0, 0, 16'h0000, 0);
    tv[6]  = v(2'b10, 3'b010, 0, 16'h7777, 16'hCAFE, 0, 1, 0, 0, 16'h57C0, 0, 0, 16'h0000, 0);
    tv[7]  = v(2'b10, 3'b010, 0, 16'h7777, 16'hCAFE, 0, 0, 0, 0, 16'hCAFE, 1, 0, 16'h0000, 0);
    tv[8]  = v(2'b10, 3'b011, 0, 16'h5A5A, 0, 0, 0, 0, 0, 16'hCAFE, 0, 0, 16'h0000, 0);
    tv[9]  = v(2'b10, 3'b001, 1, 16'h1111, 0, 0, 0, 0, 0, 16'hCAFE, 0, 0, 16'h5A5A, 1);
    tv[10] = v(2'b10, 3'b001, 0, 16'h2222, 0, 0, 0, 0, 1, 16'hCAFE, 0, 0, 16'h5A5A, 1);
    tv[11] = v(2'b10, 3'b001, 0, 16'h2222, 0, 0, 0, 0, 1, 16'hCAFE, 0, 0, 16'h5A5A, 1);
    tv[12] = v(2'b10, 3'b001, 0, 16'h2222, 0, 0, 0, 0, 1, 16'hCAFE, 0, 0, 16'h5A5A, 1);
    tv[13] = v(2'b10, 3'b001, 0, 16'h2222, 0, 0, 0, 1, 0, 16'h1111, 1, 0, 16'h5A5A, 0);
    tv[14] = v(2'b10, 3'b011, 0, 16'h2222, 0, 0, 0, 1, 0, 16'h1111, 0, 0, 16'h5A5A, 0);
    tv[15] = v(2'b11, 3'b001, 1, 0, 0, 0, 0, 1, 0, 16'h1111, 0, 0, 16'h2222, 1);
    tv[16] = v(2'b11, 3'b011, 0, 0, 0, 0, 0, 1, 0, 16'h1111, 0, 0, 16'h2222, 0);
    tv[17] = v(2'b11, 3'b001, 1, 0, 0, 0, 1, 0, 0, 16'h1111, 0, 0, 16'h2222, 0);
    tv[18] = v(2'b11, 3'b001, 1, 0, 0, 0, 0, 0, 0, 16'h1111, 0, 0, 16'h0000, 1);
    tv[19] = v(2'b11, 3'b011, 0, 0, 0, 0, 0, 1, 0, 16'h1111, 0, 0, 16'h0000, 0);
    tv[20] = v(2'b11, 3'b110, 0, 0, 16'h9999, 16'h8888, 0, 0, 0, 16'h1111, 0, 0, 16'h0000, 0);
    tv[21] = v(2'b11, 3'b111, 0, 0, 16'h9999, 16'h8888, 0, 0, 0, 16'h1111, 0, 0, 16'h0000, 0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      ps_bc_drr_slct = tv[i].drr; ps_bc_di_slct = tv[i].di; ps_bc_dm_wr = tv[i].dmwr;
      rf_bc_rdata = tv[i].rf; ps_imm_data = tv[i].imm; dm_bc_rdata = tv[i].dm;
      ps_stall = tv[i].stall; dm_bc_wr_rdy = tv[i].rdy;
      #1;
      chk1($sformatf("tv%0d_sreq", i), bc_stall_req, tv[i].e_sreq);
      @(posedge clk);
      #1;
      chk16($sformatf("tv%0d_data", i), bc_dst_data, tv[i].e_data);
      chk1($sformatf("tv%0d_vld", i), bc_dst_vld, tv[i].e_vld);
      chk1($sformatf("tv%0d_iadd", i), bc_iadd_vld, tv[i].e_iadd);
      chk16($sformatf("tv%0d_wdata", i), bc_dm_wdata, tv[i].e_wd);
      chk1($sformatf("tv%0d_wvld", i), bc_dm_wr_vld, tv[i].e_wv);
    end

    // Reset asserted while a DM write is waiting.
    @(negedge clk);
    idle_inputs();
    ps_bc_drr_slct = 2'b10; rf_bc_rdata = 16'h5A5A;
    @(negedge clk);
    ps_bc_drr_slct = 2'b11; ps_bc_di_slct = 3'b001; ps_bc_dm_wr = 1;
    @(posedge clk);
    #1 chk1("rstw_wvld_up", bc_dm_wr_vld, 1'b1);
    @(negedge clk);
    ps_bc_di_slct = 3'b011; ps_bc_dm_wr = 0;
    #1 chk1("rstw_sreq_up", bc_stall_req, 1'b1);
    #1 rst_n = 0;
    #1 check_all_zero("rstw");
    @(negedge clk);
    rst_n = 1;
    ps_bc_drr_slct = 2'b10; rf_bc_rdata = 16'h3C3C;
    @(negedge clk);
    ps_bc_drr_slct = 2'b11; ps_bc_di_slct = 3'b001; ps_bc_dm_wr = 1; dm_bc_wr_rdy = 1;
    @(posedge clk);
    #1 chk1("post_rst_wvld", bc_dm_wr_vld, 1'b1);
    chk16("post_rst_wdata", bc_dm_wdata, 16'h3C3C);
    @(negedge clk);
    ps_bc_di_slct = 3'b011; ps_bc_dm_wr = 0;
    @(posedge clk);
    #1 chk1("post_rst_done", bc_dm_wr_vld, 1'b0);

    // Execute writes ureg 3 while decode reads ureg 3.
    @(negedge clk);
    ps_bc_di_slct = 3'b010; ps_imm_data = 16'h0F0F; ps_bc_dst_ureg = 4'd3; ps_bc_dst_we = 1;
    ps_bc_drr_slct = 2'b10; ps_bc_src_ureg = 4'd3; rf_bc_rdata = 16'h1111;
    @(posedge clk);
    #1 chk16("fwd_exec", bc_dst_data, 16'h0F0F);
    @(negedge clk);
    ps_bc_di_slct = 3'b001; ps_bc_dm_wr = 0; ps_bc_drr_slct = 2'b11; ps_bc_dst_we = 0;
    @(posedge clk);
`ifdef PS_BC_FWD_EN
    #1 chk16("fwd_drr", bc_dst_data, 16'h0F0F);
`else
    #1 chk16("fwd_drr", bc_dst_data, 16'h1111);
`endif

    // Random traffic against the model.
    idle_inputs();
    do_reset();
    m_drr = 0; m_data = 0; m_wd = 0; m_vld = 0; m_iadd = 0; m_wait = 0;
    for (int c = 0; c < 600; c++) begin
      logic sreq_exp;
      @(negedge clk);
      ps_stall       = ($urandom_range(0, 7) == 0);
      ps_bc_drr_slct = 2'($urandom_range(0, 3));
      ps_bc_di_slct  = 3'($urandom_range(0, 7));
      ps_bc_dm_wr    = 1'($urandom_range(0, 1));
      rf_bc_rdata    = 16'($urandom);
      dag_bc_rdata   = 16'($urandom);
      stk_bc_rdata   = 16'($urandom);
      ps_imm_data    = 16'($urandom);
      dm_bc_rdata    = 16'($urandom);
      ps_bc_src_ureg = 4'($urandom_range(0, 4));
      ps_bc_dst_ureg = 4'($urandom_range(0, 4));
      ps_bc_dst_we   = 1'($urandom_range(0, 1));
      dm_bc_wr_rdy   = 1'($urandom_range(0, 1));
      #1;
      model_step(sreq_exp);
      chk1($sformatf("rnd%0d_sreq", c), bc_stall_req, sreq_exp);
      @(posedge clk);
      #1;
      chk16($sformatf("rnd%0d_data", c), bc_dst_data, m_data);
      chk1($sformatf("rnd%0d_vld", c), bc_dst_vld, m_vld);
      chk1($sformatf("rnd%0d_iadd", c), bc_iadd_vld, m_iadd);
      chk16($sformatf("rnd%0d_wdata", c), bc_dm_wdata, m_wd);
      chk1($sformatf("rnd%0d_wvld", c), bc_dm_wr_vld, m_wait);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
